uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receive engine: the next-generation serial receiver for the UART interface controller. It recovers frames from the asynchronous `rxd` line and hands completed words to the consumer over a valid/ready handshake.
- Frame format: start bit, 5–9 data bits LSB first, optional parity, 1 or 2 stop bits.
- Line handling: 2-flop synchroniser, mid-bit sampling from an internal baud counter, false-start rejection.
- Reporting: parity, framing and overrun errors.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `CLKS_PER_BIT`, default 16: clk cycles per bit period, legal ≥4; `HALF` = `CLKS_PER_BIT/2` (floor).
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `clk`, input, 1: clock; all logic on rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `rxd`, input, 1: asynchronous serial line, idle high.
- `data_out`, output, `DATA_BITS`: received word; stable while `valid`=1.
- `valid`, output, 1: `data_out` and error flags hold a word.
- `ready`, input, 1: consumer accepts the word when `valid`&`ready`.
- `parity_err`, output, 1: parity mismatch for the held word; always 0 when `PARITY`=0.
- `frame_err`, output, 1: a stop bit was sampled low for the held word.
- `overrun`, output, 1: one-cycle pulse when a completed word is dropped.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- **Synchroniser:** `rxd` passes through 2 flops to give `rxd_s`; an edge register holds the previous `rxd_s`.
- **IDLE:**
  - A falling edge (previous 1, current 0) goes to START and loads the baud counter.
  - A line held low (break) never retriggers; a new frame needs `rxd_s` high first.
- **START:**
  - After `HALF` cycles, sample `rxd_s`.
  - If 1: false start, return to IDLE, no output, no flags.
  - If 0: go to DATA with the bit index at 0.
- **DATA:**
  - Sample every `CLKS_PER_BIT` cycles; shift the bit into the MSB of the shift register (LSB-first line order).
  - After `DATA_BITS` samples, go to PARITY if `PARITY`≠0, else STOP.
- **PARITY:**
  - Sample 1 bit and compare it with the expected value.
  - Expected value is XOR of the data bits for even parity, its inverse for odd.
  - A mismatch sets the pending `parity_err`.
- **STOP:**
  - Sample `STOP_BITS` bits at `CLKS_PER_BIT` spacing; any 0 sets the pending `frame_err`.
  - At the last stop sample, complete the word and return to IDLE mid-stop-bit, so the next start edge is caught with no gap.
- **Completion:**
  - A word with `frame_err` is still delivered.
  - If `valid`=0, or `valid`&`ready` in the same cycle: load `data_out` and both error flags, and `valid`←1.
  - If `valid`=1 and `ready`=0: drop the new word, keep the held word and flags, and pulse `overrun` for 1 cycle.
- **Handshake:** `valid`&`ready` with no completion in that cycle clears `valid` next cycle. `data_out` and the flags keep their last value.
- **Reset:**
  - `rst`=1 at any point, including mid-frame, returns the FSM to IDLE and clears the counters.
  - All outputs go to 0 (`data_out`, `valid`, `parity_err`, `frame_err`, `overrun`, `busy`).
  - The synchroniser flops reset to 1 (idle line), so no false edge appears after reset.
  - A partial frame is discarded.
- **Baud counter:** width is `$clog2(CLKS_PER_BIT)` bits and it never wraps past `CLKS_PER_BIT-1`. The bit index is wide enough for `DATA_BITS`.

## Timing
- `rxd` to `rxd_s` latency: 2 cycles.
- Let t0 be the cycle the falling edge is registered (`busy` goes 1 at t0+1).
- Start sample at t0+`HALF`.
- Data bit i (0-based) sampled at t0+`HALF`+(i+1)·`CLKS_PER_BIT`.
- Let N = `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`.
- Last stop sample at t0+`HALF`+N·`CLKS_PER_BIT`.
- `valid` (or `overrun`) asserts at t0+`HALF`+N·`CLKS_PER_BIT`+1.
- `busy` falls in the same cycle.
- Back-to-back frames are accepted at full line rate.
- `valid` can stay continuously high across words if `ready` is asserted on each completion cycle.

## Test plan
- **Basic frame with even parity:** `DATA_BITS`=8, `CLKS_PER_BIT`=16, `PARITY`=2, `STOP_BITS`=1; send 0xA5 with parity bit 0 → `valid` at t0+169, `data_out`=0xA5, `parity_err`=0, `frame_err`=0; `ready` pulse clears `valid` next cycle.
- **Parity error:** same config; send 0x3C with parity bit 1 → `data_out`=0x3C, `parity_err`=1. Next frame 0x3C with parity 0 → `parity_err`=0.
- **Framing error:** send 0x81 with the stop bit held low → `frame_err`=1, `data_out`=0x81. The line stays low for 40 cycles, then rises → no second `valid`, and the next frame is received correctly.
- **False start:** drive `rxd` low for 4 cycles, then high → `busy` pulses, `valid` never asserts, no flags.
- **Overrun:** `ready`=0; send 0x11 then 0x22 back-to-back → `data_out` stays 0x11, `overrun` is a single-cycle pulse at frame 2 completion. With `ready`=1 on the completion cycle of 0x33 → `data_out`=0x33, `valid` stays 1.
- **Reset and config sweep:** assert `rst` mid-data-bit 4 → all outputs 0, no `valid`; next full frame 0x5A is received. Repeat with `DATA_BITS`=7, `PARITY`=1, `STOP_BITS`=2, `CLKS_PER_BIT`=5; frame 0x55 → `valid` at t0+2+10·5+1=t0+53.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receive engine.
// Start bit, DATA_BITS data bits LSB first, optional odd/even parity and
// STOP_BITS stop bits. Uses mid-bit sampling from an internal baud counter.
// Completed words are offered on a valid/ready handshake, with parity,
// framing and overrun reporting.
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Expected parity bit: XOR of the data for even parity, inverted for odd.
    function automatic logic parity_expect(input logic [DATA_BITS-1:0] d);
        logic x;
        x = ^d;
        if (PARITY == 1) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   rxd_meta_r;
    logic                   rxd_sync_r;
    logic                   rxd_prev_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   par_pend_r;
    logic                   frm_pend_r;
    logic                   fall_s;
    logic                   sample_s;
    logic                   complete_s;

    // Falling edge on the synchronised line; a held-low line never produces one.
    assign fall_s = rxd_prev_r & ~rxd_sync_r;

    // Two-flop synchroniser plus edge register; idle-high after reset so no false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // Next-state logic: sample strobes and word completion.
    always_comb begin
        state_next_s = state_r;
        sample_s     = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    sample_s = 1'b1;
                    if (rxd_sync_r) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    sample_s = 1'b1;
                    if (idx_r == DATA_LAST) begin
                        state_next_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    sample_s     = 1'b1;
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    sample_s = 1'b1;
                    if (idx_r == STOP_LAST) begin
                        complete_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_STOP;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; busy is registered from the next state so it tracks "not IDLE".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s != ST_IDLE);
        end
    end

    // Baud counter, bit index, shift register and pending error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= CNT_ZERO;
            idx_r      <= IDX_ZERO;
            shift_r    <= {DATA_BITS{1'b0}};
            par_pend_r <= 1'b0;
            frm_pend_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r      <= CNT_ZERO;
                    idx_r      <= IDX_ZERO;
                    par_pend_r <= 1'b0;
                    frm_pend_r <= 1'b0;
                end
                ST_START: begin
                    cnt_r <= sample_s ? CNT_ZERO : cnt_r + CNT_ONE;
                    idx_r <= IDX_ZERO;
                end
                ST_DATA: begin
                    if (sample_s) begin
                        cnt_r   <= CNT_ZERO;
                        shift_r <= {rxd_sync_r, shift_r[DATA_BITS-1:1]};
                        idx_r   <= (idx_r == DATA_LAST) ? IDX_ZERO : idx_r + IDX_ONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (sample_s) begin
                        cnt_r      <= CNT_ZERO;
                        par_pend_r <= (rxd_sync_r != parity_expect(shift_r));
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (sample_s) begin
                        cnt_r <= CNT_ZERO;
                        idx_r <= idx_r + IDX_ONE;
                        if (!rxd_sync_r) begin
                            frm_pend_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                    idx_r <= IDX_ZERO;
                end
            endcase
        end
    end

    // Output holding register: load on completion when free, otherwise flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= {DATA_BITS{1'b0}};
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete_s) begin
                if (!valid || ready) begin
                    data_out   <= shift_r;
                    parity_err <= (PARITY != 0) ? par_pend_r : 1'b0;
                    frame_err  <= frm_pend_r | ~rxd_sync_r;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end else begin
                valid <= valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: scoreboard of expected words, checked by a
// negedge monitor, on an 8E1/16x instance and a 7O2/5x instance.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd_a, rxd_b, ready_a, ready_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, pe_a, fe_a, ov_a, busy_a;
    logic       valid_b, pe_b, fe_b, ov_b, busy_b;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .data_out(data_a), .valid(valid_a), .ready(ready_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_param #(.DATA_BITS(7), .CLKS_PER_BIT(5), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .data_out(data_b), .valid(valid_b), .ready(ready_b),
        .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .busy(busy_b)
    );

    typedef struct {
        int         which;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        int         t_exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_words[2];
    int   n_ovr[2];
    bit   busy_seen[2];
    bit   prev_valid[2];
    bit   prev_acc[2];

    // Cycle counter; after rising edge k it reads k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A new word is visible when valid rises, or stays high after an accept.
    task automatic mon_step(input int k, input logic v, input logic r, input logic [8:0] d,
                            input logic pe, input logic fe, input logic ov, input logic b);
        exp_t e;
        if (ov) n_ovr[k]++;
        if (b) busy_seen[k] = 1'b1;
        if (v && (!prev_valid[k] || prev_acc[k])) begin
            n_words[k]++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("word_source", 32'(k), 32'(e.which));
                check_eq("data_out", 32'(d), 32'(e.data));
                check_eq("parity_err", 32'(pe), 32'(e.pe));
                check_eq("frame_err", 32'(fe), 32'(e.fe));
                if (e.t_exp >= 0) check_eq("valid_cycle", 32'(cyc), 32'(e.t_exp));
            end
        end
        prev_valid[k] = v;
        prev_acc[k]   = v && r;
    endtask

    always @(negedge clk) begin
        mon_step(0, valid_a, ready_a, {1'b0, data_a}, pe_a, fe_a, ov_a, busy_a);
        mon_step(1, valid_b, ready_b, {2'b00, data_b}, pe_b, fe_b, ov_b, busy_b);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rxd_a = v;
        else rxd_b = v;
    endtask

    task automatic drive_bit(input int which, input logic v, input int cpb);
        set_line(which, v);
        repeat (cpb) @(posedge clk);
        #1;
    endtask

    // par_bit < 0 means no parity bit on the line.
    task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                              input int par_bit, input int nstop, input logic stop_v, input int cpb);
        drive_bit(which, 1'b0, cpb);
        for (int i = 0; i < nbits; i++) drive_bit(which, d[i], cpb);
        if (par_bit >= 0) drive_bit(which, par_bit[0], cpb);
        for (int i = 0; i < nstop; i++) drive_bit(which, stop_v, cpb);
    endtask

    // Expected observation cycle = drive cycle + 2 (sync) + 1 (edge seen) + HALF + N*CLKS_PER_BIT.
    task automatic push(input int which, input logic [8:0] d, input logic pe, input logic fe, input int t);
        exp_t e;
        e.which = which; e.data = d; e.pe = pe; e.fe = fe; e.t_exp = t;
        exp_q.push_back(e);
    endtask

    task automatic accept(input int which);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = (which == 0) ? valid_a : valid_b;
        end
        check_eq("accept_wait", 32'(got), 32'd1);
        sync();
        if (which == 0) ready_a = 1'b1; else ready_b = 1'b1;
        sync();
        if (which == 0) ready_a = 1'b0; else ready_b = 1'b0;
        @(negedge clk);
        check_eq("valid_clears", 32'((which == 0) ? valid_a : valid_b), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int ov0;
        rst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_data_a", 32'(data_a), 32'd0);
        check_eq("rst_valid_a", 32'(valid_a), 32'd0);
        check_eq("rst_flags_a", 32'({pe_a, fe_a, ov_a}), 32'd0);
        check_eq("rst_busy_a", 32'(busy_a), 32'd0);
        check_eq("rst_valid_b", 32'(valid_b), 32'd0);
        check_eq("rst_busy_b", 32'(busy_b), 32'd0);
        sync();
        rst = 1'b0;
        repeat (4) sync();

        // Basic 0xA5, even parity bit 0
        push(0, 9'h0A5, 1'b0, 1'b0, cyc + 171);
        send_frame(0, 9'h0A5, 8, 0, 1, 1'b1, 16);
        accept(0);

        // Parity error then clean frame with the same data
        sync();
        push(0, 9'h03C, 1'b1, 1'b0, cyc + 171);
        send_frame(0, 9'h03C, 8, 1, 1, 1'b1, 16);
        accept(0);
        sync();
        push(0, 9'h03C, 1'b0, 1'b0, cyc + 171);
        send_frame(0, 9'h03C, 8, 0, 1, 1'b1, 16);
        accept(0);

        // Framing error: stop low, line held low 40 more cycles (break)
        sync();
        push(0, 9'h081, 1'b0, 1'b1, cyc + 171);
        send_frame(0, 9'h081, 8, 0, 1, 1'b0, 16);
        repeat (40) sync();
        rxd_a = 1'b1;
        accept(0);
        w = n_words[0];
        repeat (60) sync();
        check_eq("break_no_word", 32'(n_words[0]), 32'(w));
        push(0, 9'h042, 1'b0, 1'b0, cyc + 171);
        send_frame(0, 9'h042, 8, 0, 1, 1'b1, 16);
        accept(0);

        // False start: 4 cycles low
        w = n_words[0];
        busy_seen[0] = 1'b0;
        sync();
        rxd_a = 1'b0;
        repeat (4) sync();
        rxd_a = 1'b1;
        repeat (30) sync();
        check_eq("false_start_busy_seen", 32'(busy_seen[0]), 32'd1);
        check_eq("false_start_no_word", 32'(n_words[0]), 32'(w));
        check_eq("false_start_busy_end", 32'(busy_a), 32'd0);
        check_eq("false_start_valid", 32'(valid_a), 32'd0);
        check_eq("false_start_flags", 32'({pe_a, fe_a}), 32'd0);

        // Overrun: 0x11 held, 0x22 dropped
        ov0 = n_ovr[0];
        sync();
        push(0, 9'h011, 1'b0, 1'b0, cyc + 171);
        send_frame(0, 9'h011, 8, 0, 1, 1'b1, 16);
        send_frame(0, 9'h022, 8, 0, 1, 1'b1, 16);
        repeat (3) sync();
        check_eq("overrun_pulses", 32'(n_ovr[0]), 32'(ov0 + 1));
        check_eq("overrun_hold_data", 32'(data_a), 32'h11);
        check_eq("overrun_hold_valid", 32'(valid_a), 32'd1);

        // 0x33 with ready only on its completion cycle: valid stays high
        sync();
        push(0, 9'h033, 1'b0, 1'b0, cyc + 171);
        fork
            send_frame(0, 9'h033, 8, 0, 1, 1'b1, 16);
            begin
                repeat (170) @(posedge clk);
                #1 ready_a = 1'b1;
                @(posedge clk);
                #1 ready_a = 1'b0;
            end
        join
        check_eq("replace_valid", 32'(valid_a), 32'd1);
        check_eq("replace_data", 32'(data_a), 32'h33);
        check_eq("replace_no_overrun", 32'(n_ovr[0]), 32'(ov0 + 1));

        // Reset in the middle of data bit 4 of 0x5A
        sync();
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(0, (i == 1 || i == 3) ? 1'b1 : 1'b0, 16);
        rxd_a = 1'b1;
        repeat (8) sync();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_data", 32'(data_a), 32'd0);
        check_eq("midrst_valid", 32'(valid_a), 32'd0);
        check_eq("midrst_busy", 32'(busy_a), 32'd0);
        check_eq("midrst_flags", 32'({pe_a, fe_a, ov_a}), 32'd0);
        sync();
        rst = 1'b0;
        repeat (5) sync();
        w = n_words[0];
        check_eq("midrst_no_word", 32'(n_words[0]), 32'd7);
        push(0, 9'h05A, 1'b0, 1'b0, cyc + 171);
        send_frame(0, 9'h05A, 8, 0, 1, 1'b1, 16);
        accept(0);

        // 7O2 at 5 clocks per bit: 0x55 (odd parity bit 1), 0x2A with wrong parity
        sync();
        push(1, 9'h055, 1'b0, 1'b0, cyc + 55);
        send_frame(1, 9'h055, 7, 1, 2, 1'b1, 5);
        accept(1);
        sync();
        push(1, 9'h02A, 1'b1, 1'b0, cyc + 55);
        send_frame(1, 9'h02A, 7, 1, 2, 1'b1, 5);
        accept(1);

        repeat (10) sync();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("words_a", 32'(n_words[0]), 32'd8);
        check_eq("words_b", 32'(n_words[1]), 32'd2);
        check_eq("overrun_b", 32'(n_ovr[1]), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
